// File: rtl/axi4_reg_slice_if.sv
// Default AXI4 widths and the full AXI4 interface used on both sides of axi4_reg_slice.
package axi4_reg_slice_pkg;
  localparam int DEFAULT_AXI4_DATA_WIDTH = 64;
  localparam int DEFAULT_AXI4_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI4_ID_WIDTH   = 4;
  localparam int DEFAULT_AXI4_USER_WIDTH = 1;
endpackage

interface axi4_if
  import axi4_reg_slice_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_AXI4_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_AXI4_ADDR_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_AXI4_ID_WIDTH,
  parameter int USER_WIDTH = DEFAULT_AXI4_USER_WIDTH
);
  logic                    aclk;
  logic                    aresetn;

  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    input  aclk, aresetn,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice with per-channel bypass / forward / full (skid) modes.
// Optional stall counters are built when AXI4_REG_SLICE_STALL_CNT_EN is defined.

// state | meaning (MODE 2 only)
// EMPTY | nothing held, in_ready=1 (0 while in reset), out_valid=0
// ONE   | one beat in main register, in_ready=1, out_valid=1
// FULL  | main and skid registers both held, in_ready=0, out_valid=1
module axi4_reg_slice_chan #(
  parameter int WIDTH = 8,
  parameter int MODE  = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
  input  logic             stat_clr,
  output logic [15:0]      stall_cnt,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  if (MODE == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
  end else if (MODE == 1) begin : g_fwd
    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;
    always_ff @(posedge clk) begin
      if (rst)           vld_q <= 1'b0;
      else if (in_ready) vld_q <= in_valid;
    end
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) data_q <= in_data;
    end
  end else begin : g_full
    state_t           state;
    logic             rdy_q, vld_q, push, pop;
    logic [WIDTH-1:0] main_q, skid_q;
    assign push      = in_valid && rdy_q;
    assign pop       = vld_q && out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_data  = main_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= EMPTY;
        rdy_q <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            rdy_q <= 1'b1;
            if (push) begin
              state <= ONE;
              vld_q <= 1'b1;
            end
          end
          ONE: begin
            if (push && !pop) begin
              state <= FULL;
              rdy_q <= 1'b0;
            end else if (!push && pop) begin
              state <= EMPTY;
              vld_q <= 1'b0;
            end
          end
          FULL: begin
            if (pop) begin
              state <= ONE;
              rdy_q <= 1'b1;
            end
          end
          default: begin
            state <= EMPTY;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
          end
        endcase
      end
    end

    // A push in FULL cannot happen, so the skid only fills from ONE when the main beat stalls.
    always_ff @(posedge clk) begin
      if (push && (state == EMPTY || pop)) main_q <= in_data;
      else if (state == FULL && pop)       main_q <= skid_q;
      if (push && state == ONE && !pop)    skid_q <= in_data;
    end
  end

`ifdef AXI4_REG_SLICE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr)
      stall_cnt <= 16'h0000;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

module axi4_reg_slice
  import axi4_reg_slice_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_AXI4_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_AXI4_ADDR_WIDTH,
  parameter int ID_WIDTH   = DEFAULT_AXI4_ID_WIDTH,
  parameter int USER_WIDTH = DEFAULT_AXI4_USER_WIDTH,
  parameter int AW_MODE    = 2,
  parameter int W_MODE     = 2,
  parameter int B_MODE     = 2,
  parameter int AR_MODE    = 2,
  parameter int R_MODE     = 2
) (
  input  logic        aclk,
  input  logic        areset,
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
  input  logic        stat_clr,
  output logic [15:0] stall_cnt_aw,
  output logic [15:0] stall_cnt_w,
  output logic [15:0] stall_cnt_b,
  output logic [15:0] stall_cnt_ar,
  output logic [15:0] stall_cnt_r,
`endif
  axi4_if.slave       s_axi,
  axi4_if.master      m_axi
);
  localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_WIDTH;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH;
  localparam int B_W  = ID_WIDTH + 2 + USER_WIDTH;
  localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1 + USER_WIDTH;

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  logic unused_if_clk;
  assign unused_if_clk = &{1'b0, s_axi.aclk, s_axi.aresetn, m_axi.aclk, m_axi.aresetn};

  assign aw_in = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst, s_axi.awlock,
                  s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion, s_axi.awuser};
  assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
          m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion, m_axi.awuser} = aw_out;
  assign ar_in = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst, s_axi.arlock,
                  s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion, s_axi.aruser};
  assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
          m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion, m_axi.aruser} = ar_out;
  assign w_in  = {s_axi.wdata, s_axi.wstrb, s_axi.wlast, s_axi.wuser};
  assign {m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wuser} = w_out;
  assign b_in  = {m_axi.bid, m_axi.bresp, m_axi.buser};
  assign {s_axi.bid, s_axi.bresp, s_axi.buser} = b_out;
  assign r_in  = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.ruser};
  assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.ruser} = r_out;

  axi4_reg_slice_chan #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .clk(aclk), .rst(areset),
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt_aw),
`endif
    .in_valid(s_axi.awvalid), .in_ready(s_axi.awready), .in_data(aw_in),
    .out_valid(m_axi.awvalid), .out_ready(m_axi.awready), .out_data(aw_out)
  );

  axi4_reg_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .clk(aclk), .rst(areset),
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt_w),
`endif
    .in_valid(s_axi.wvalid), .in_ready(s_axi.wready), .in_data(w_in),
    .out_valid(m_axi.wvalid), .out_ready(m_axi.wready), .out_data(w_out)
  );

  axi4_reg_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .clk(aclk), .rst(areset),
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt_b),
`endif
    .in_valid(m_axi.bvalid), .in_ready(m_axi.bready), .in_data(b_in),
    .out_valid(s_axi.bvalid), .out_ready(s_axi.bready), .out_data(b_out)
  );

  axi4_reg_slice_chan #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .clk(aclk), .rst(areset),
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt_ar),
`endif
    .in_valid(s_axi.arvalid), .in_ready(s_axi.arready), .in_data(ar_in),
    .out_valid(m_axi.arvalid), .out_ready(m_axi.arready), .out_data(ar_out)
  );

  axi4_reg_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk(aclk), .rst(areset),
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    .stat_clr(stat_clr), .stall_cnt(stall_cnt_r),
`endif
    .in_valid(m_axi.rvalid), .in_ready(m_axi.rready), .in_data(r_in),
    .out_valid(s_axi.rvalid), .out_ready(s_axi.rready), .out_data(r_out)
  );
endmodule

// File: tb/tb_axi4_reg_slice.sv
// Randomized bench for axi4_reg_slice: AW/W/AR full, B bypass, R forward, against a queue model.
module tb_axi4_reg_slice;
  localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;
  localparam int TIMEOUT = 3000;

  logic clk = 1'b0;
  logic areset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   modes [5] = '{2, 2, 0, 2, 1};
  logic [127:0] stim_q[$];

`ifdef AXI4_REG_SLICE_STALL_CNT_EN
  logic        stat_clr;
  logic [15:0] stall_cnt_aw, stall_cnt_w, stall_cnt_b, stall_cnt_ar, stall_cnt_r;
`endif

  axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2)) s_if ();
  axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2)) m_if ();

  assign s_if.aclk = clk;
  assign m_if.aclk = clk;
  assign s_if.aresetn = ~areset;
  assign m_if.aresetn = ~areset;

  axi4_reg_slice #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(2),
    .AW_MODE(2), .W_MODE(2), .B_MODE(0), .AR_MODE(2), .R_MODE(1)
  ) dut (
    .aclk(clk),
    .areset(areset),
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    .stat_clr(stat_clr),
    .stall_cnt_aw(stall_cnt_aw), .stall_cnt_w(stall_cnt_w), .stall_cnt_b(stall_cnt_b),
    .stall_cnt_ar(stall_cnt_ar), .stall_cnt_r(stall_cnt_r),
`endif
    .s_axi(s_if),
    .m_axi(m_if)
  );

  always #5 clk = ~clk;

  function automatic int pw(input int ch);
    case (ch)
      CH_AW, CH_AR: return 67;
      CH_W:         return 39;
      CH_B:         return 8;
      default:      return 41;
    endcase
  endfunction

  function automatic logic [127:0] rnd(input int ch);
    logic [127:0] x;
    x = {$urandom, $urandom, $urandom, $urandom};
    return x & ((128'd1 << pw(ch)) - 128'd1);
  endfunction

  task automatic drive(input int ch, input logic v, input logic [127:0] p, input logic r);
    case (ch)
      CH_AW: begin
        s_if.awvalid = v;
        {s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst, s_if.awlock,
         s_if.awcache, s_if.awprot, s_if.awqos, s_if.awregion, s_if.awuser} = p[66:0];
        m_if.awready = r;
      end
      CH_W: begin
        s_if.wvalid = v;
        {s_if.wdata, s_if.wstrb, s_if.wlast, s_if.wuser} = p[38:0];
        m_if.wready = r;
      end
      CH_B: begin
        m_if.bvalid = v;
        {m_if.bid, m_if.bresp, m_if.buser} = p[7:0];
        s_if.bready = r;
      end
      CH_AR: begin
        s_if.arvalid = v;
        {s_if.arid, s_if.araddr, s_if.arlen, s_if.arsize, s_if.arburst, s_if.arlock,
         s_if.arcache, s_if.arprot, s_if.arqos, s_if.arregion, s_if.aruser} = p[66:0];
        m_if.arready = r;
      end
      default: begin
        m_if.rvalid = v;
        {m_if.rid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.ruser} = p[40:0];
        s_if.rready = r;
      end
    endcase
  endtask

  task automatic sample(input int ch, output logic ov, output logic ir, output logic [127:0] p);
    p = '0;
    case (ch)
      CH_AW: begin
        ov = m_if.awvalid; ir = s_if.awready;
        p[66:0] = {m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst, m_if.awlock,
                   m_if.awcache, m_if.awprot, m_if.awqos, m_if.awregion, m_if.awuser};
      end
      CH_W: begin
        ov = m_if.wvalid; ir = s_if.wready;
        p[38:0] = {m_if.wdata, m_if.wstrb, m_if.wlast, m_if.wuser};
      end
      CH_B: begin
        ov = s_if.bvalid; ir = m_if.bready;
        p[7:0] = {s_if.bid, s_if.bresp, s_if.buser};
      end
      CH_AR: begin
        ov = m_if.arvalid; ir = s_if.arready;
        p[66:0] = {m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst, m_if.arlock,
                   m_if.arcache, m_if.arprot, m_if.arqos, m_if.arregion, m_if.aruser};
      end
      default: begin
        ov = s_if.rvalid; ir = m_if.rready;
        p[40:0] = {s_if.rid, s_if.rdata, s_if.rresp, s_if.rlast, s_if.ruser};
      end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1 areset = 1'b1;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
  endtask

  // Sends stim_q through one channel; rmode 0 random ready, 1 toggling, 2 low for 5 cycles.
  task automatic run_chan(input int ch, input int vpct, input int rmode, input int rpct,
                          output int n_out, output int n_cyc);
    logic [127:0] exp_q[$];
    logic [127:0] p, op, exp_p;
    logic v, r, ov, ir, exp_ov, exp_ir;
    bit   tog;
    int   mode;
    mode = modes[ch];
    n_out = 0; n_cyc = 0; tog = 1'b1;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n_cyc < TIMEOUT) begin
      @(posedge clk); #1;
      v = (stim_q.size() > 0) && ($urandom_range(99) < vpct);
      case (rmode)
        0:       r = ($urandom_range(99) < rpct);
        1:       r = tog;
        default: r = (n_cyc >= 5);
      endcase
      tog = ~tog;
      p = v ? stim_q[0] : rnd(ch);
      drive(ch, v, p, r);
      #3;
      sample(ch, ov, ir, op);
      if (mode == 0) begin
        exp_ov = v; exp_ir = r; exp_p = p;
      end else begin
        exp_ov = (exp_q.size() > 0);
        exp_ir = (mode == 1) ? (exp_q.size() == 0 || r) : (exp_q.size() < 2);
        exp_p  = exp_ov ? exp_q[0] : '0;
      end
      n_checks++;
      if (ov !== exp_ov) begin
        n_errors++;
        $display("FAIL valid ch%0d cyc%0d: got %0b, expected %0b", ch, n_cyc, ov, exp_ov);
      end
      n_checks++;
      if (ir !== exp_ir) begin
        n_errors++;
        $display("FAIL ready ch%0d cyc%0d: got %0b, expected %0b", ch, n_cyc, ir, exp_ir);
      end
      if (exp_ov && ov) begin
        n_checks++;
        if (op !== exp_p) begin
          n_errors++;
          $display("FAIL payload ch%0d cyc%0d: got %0h, expected %0h", ch, n_cyc, op, exp_p);
        end
      end
      if (mode == 0) begin
        if (v && r) begin
          void'(stim_q.pop_front());
          n_out++;
        end
      end else begin
        if (exp_ov && r) begin
          void'(exp_q.pop_front());
          n_out++;
        end
        if (v && exp_ir) exp_q.push_back(stim_q.pop_front());
      end
      n_cyc++;
    end
    n_checks++;
    if (n_cyc >= TIMEOUT) begin
      n_errors++;
      $display("FAIL timeout ch%0d: got %0d cycles, expected fewer than %0d", ch, n_cyc, TIMEOUT);
    end
    @(posedge clk); #1;
    drive(ch, 1'b0, rnd(ch), 1'b0);
    stim_q.delete();
  endtask

  task automatic test_reset();
    logic ov, ir;
    logic [127:0] op;
    for (int ch = 0; ch < 5; ch++) drive(ch, 1'b0, '0, 1'b0);
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    for (int ch = 0; ch < 5; ch++) begin
      sample(ch, ov, ir, op);
      n_checks++;
      if (ov !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_valid ch%0d: got %0b, expected 0", ch, ov);
      end
      if (modes[ch] == 2) begin
        n_checks++;
        if (ir !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_ready ch%0d: got %0b, expected 0", ch, ir);
        end
      end
    end
    #1 areset = 1'b0;
    @(posedge clk); #3;
    for (int ch = 0; ch < 5; ch++) begin
      sample(ch, ov, ir, op);
      if (modes[ch] != 0) begin
        n_checks++;
        if (ir !== 1'b1) begin
          n_errors++;
          $display("FAIL post_reset_ready ch%0d: got %0b, expected 1", ch, ir);
        end
      end
    end
  endtask

  task automatic test_random();
    int n_out, n_cyc;
    for (int pass = 0; pass < 2; pass++) begin
      for (int ch = 0; ch < 5; ch++) begin
        for (int i = 0; i < 40; i++) stim_q.push_back(rnd(ch));
        run_chan(ch, (pass == 0) ? 70 : 100, 0, (pass == 0) ? 60 : 30, n_out, n_cyc);
        n_checks++;
        if (n_out !== 40) begin
          n_errors++;
          $display("FAIL random_count ch%0d: got %0d beats, expected 40", ch, n_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_out, n_cyc;
    for (int i = 0; i < 100; i++) stim_q.push_back(rnd(CH_AR));
    run_chan(CH_AR, 100, 0, 100, n_out, n_cyc);
    n_checks++;
    if (n_out !== 100) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d beats, expected 100", n_out);
    end
    n_checks++;
    if (n_cyc !== 101) begin
      n_errors++;
      $display("FAIL b2b_cycles: got %0d cycles, expected 101", n_cyc);
    end
  endtask

  task automatic test_w_stall();
    int n_out, n_cyc;
    for (int i = 0; i < 4; i++) stim_q.push_back(rnd(CH_W));
    run_chan(CH_W, 100, 2, 0, n_out, n_cyc);
    n_checks++;
    if (n_out !== 4) begin
      n_errors++;
      $display("FAIL w_stall_count: got %0d beats, expected 4", n_out);
    end
  endtask

  task automatic test_r_toggle();
    int n_out, n_cyc;
    logic [127:0] p;
    for (int i = 0; i < 4; i++) begin
      p = rnd(CH_R);
      p[2] = (i == 3);
      stim_q.push_back(p);
    end
    run_chan(CH_R, 100, 1, 0, n_out, n_cyc);
    n_checks++;
    if (n_out !== 4) begin
      n_errors++;
      $display("FAIL r_toggle_count: got %0d beats, expected 4", n_out);
    end
  endtask

  task automatic test_b_bypass();
    int n_out, n_cyc;
    logic [127:0] p;
    for (int i = 0; i < 10; i++) begin
      p = rnd(CH_B);
      p[3:2] = 2'b10;
      stim_q.push_back(p);
    end
    run_chan(CH_B, 80, 0, 50, n_out, n_cyc);
    n_checks++;
    if (n_out !== 10) begin
      n_errors++;
      $display("FAIL b_bypass_count: got %0d beats, expected 10", n_out);
    end
  endtask

  task automatic test_mid_reset();
    logic ov, ir;
    logic [127:0] op, p0;
    p0 = rnd(CH_AW);
    @(posedge clk); #1 drive(CH_AW, 1'b1, p0, 1'b0);
    @(posedge clk); #1 drive(CH_AW, 1'b1, rnd(CH_AW), 1'b0);
    @(posedge clk); #3;
    sample(CH_AW, ov, ir, op);
    n_checks++;
    if ({ov, ir} !== 2'b10 || op !== p0) begin
      n_errors++;
      $display("FAIL full_state: got v=%0b r=%0b %0h, expected v=1 r=0 %0h", ov, ir, op, p0);
    end
    @(posedge clk); #1;
    areset = 1'b1;
    drive(CH_AW, 1'b0, rnd(CH_AW), 1'b0);
    @(posedge clk); #3;
    sample(CH_AW, ov, ir, op);
    n_checks++;
    if ({ov, ir} !== 2'b00) begin
      n_errors++;
      $display("FAIL mid_reset: got v=%0b r=%0b, expected v=0 r=0", ov, ir);
    end
    #1 areset = 1'b0;
    drive(CH_AW, 1'b0, rnd(CH_AW), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #3;
      sample(CH_AW, ov, ir, op);
      n_checks++;
      if ({ov, ir} !== 2'b01) begin
        n_errors++;
        $display("FAIL after_reset cyc%0d: got v=%0b r=%0b, expected v=0 r=1", i, ov, ir);
      end
    end
    #1 drive(CH_AW, 1'b0, rnd(CH_AW), 1'b0);
  endtask

`ifdef AXI4_REG_SLICE_STALL_CNT_EN
  task automatic test_stall_cnt();
    stat_clr = 1'b0;
    do_reset();
    drive(CH_AW, 1'b1, rnd(CH_AW), 1'b0);
    repeat (10) @(posedge clk);
    #2;
    n_checks++;
    if (stall_cnt_aw !== 16'd8) begin
      n_errors++;
      $display("FAIL stall_cnt_early: got %0d, expected 8", stall_cnt_aw);
    end
    repeat (70000) @(posedge clk);
    #2;
    n_checks++;
    if (stall_cnt_aw !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL stall_cnt_sat: got %0h, expected ffff", stall_cnt_aw);
    end
    stat_clr = 1'b1;
    @(posedge clk); #2;
    stat_clr = 1'b0;
    n_checks++;
    if (stall_cnt_aw !== 16'd0) begin
      n_errors++;
      $display("FAIL stall_cnt_clr: got %0h, expected 0", stall_cnt_aw);
    end
    repeat (5) @(posedge clk);
    #2;
    n_checks++;
    if (stall_cnt_aw !== 16'd5) begin
      n_errors++;
      $display("FAIL stall_cnt_restart: got %0d, expected 5", stall_cnt_aw);
    end
    drive(CH_AW, 1'b0, rnd(CH_AW), 1'b0);
    do_reset();
  endtask
`endif

  initial begin
    areset = 1'b1;
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_random();
    test_back_to_back();
    test_w_stall();
    test_r_toggle();
    test_b_bypass();
    test_mid_reset();
`ifdef AXI4_REG_SLICE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
